// File: rtl/dmem_ctrl.sv
// RV32 data memory: valid/ready request, B/H/W load-store sizing, WAIT_STATES latency.
// Define DMEM_FAULT_EN to report misaligned, out-of-range and invalid-funct3 accesses.
module dmem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        busy
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WaitInit = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q;
    logic [2:0]    funct3_q;
    logic [31:0]   addr_q, wdata_q;
    logic          accept, commit;
    logic          c_we;
    logic [2:0]    c_f3;
    logic [31:0]   c_addr, c_wdata;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic [1:0]    lane, size;
    logic          uns, fault;
    logic [3:0]    be;
    logic [31:0]   wword, rword, rdata;
    logic [15:0]   rhalf;
    logic [7:0]    rbyte;
    logic          unused_addr;

    assign req_ready = reset && (state_q != StWait);
    assign accept    = req_valid && req_ready;
    assign busy      = (state_q == StWait);
    assign rsp_valid = (state_q == StResp);

    // With no wait states the commit edge is the accept edge, so use the live request.
    assign c_we    = (WAIT_STATES == 0) ? req_we     : we_q;
    assign c_f3    = (WAIT_STATES == 0) ? req_funct3 : funct3_q;
    assign c_addr  = (WAIT_STATES == 0) ? req_addr   : addr_q;
    assign c_wdata = (WAIT_STATES == 0) ? req_wdata  : wdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            StIdle, StResp: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_d = StResp;
                        commit  = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitInit;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // size: 0 byte, 1 half, 2 word
    always_comb begin
        size  = 2'd2;
        uns   = 1'b0;
        fault = 1'b0;
        case (c_f3)
            3'b000: size = 2'd0;
            3'b001: size = 2'd1;
            3'b010: size = 2'd2;
            3'b100: if (!c_we) begin size = 2'd0; uns = 1'b1; end else fault = 1'b1;
            3'b101: if (!c_we) begin size = 2'd1; uns = 1'b1; end else fault = 1'b1;
            default: fault = 1'b1;
        endcase
`ifdef DMEM_FAULT_EN
        if ((size == 2'd1 && c_addr[0]) || (size == 2'd2 && c_addr[1:0] != 2'b00)) begin
            fault = 1'b1;
        end
        if ({2'b00, c_addr[31:2]} >= DEPTH_WORDS) begin
            fault = 1'b1;
        end
`else
        if (fault) begin
            size = 2'd2;
            uns  = 1'b0;
        end
        fault = 1'b0;
`endif
    end

    assign unused_addr = ^c_addr[31:AW+2];
    assign idx   = c_addr[AW+1:2];
    assign lane  = (size == 2'd2) ? 2'b00 : (size == 2'd1) ? {c_addr[1], 1'b0} : c_addr[1:0];
    assign rword = mem[idx];
    assign rhalf = lane[1] ? rword[31:16] : rword[15:0];
    assign rbyte = lane[0] ? rhalf[15:8] : rhalf[7:0];

    always_comb begin
        case (size)
            2'd0: begin
                rdata = uns ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
                be    = 4'b0001 << lane;
                wword = {4{c_wdata[7:0]}};
            end
            2'd1: begin
                rdata = uns ? {16'd0, rhalf} : {{16{rhalf[15]}}, rhalf};
                be    = 4'b0011 << lane;
                wword = {2{c_wdata[15:0]}};
            end
            default: begin
                rdata = rword;
                be    = 4'b1111;
                wword = c_wdata;
            end
        endcase
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (commit && c_we && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            we_q      <= 1'b0;
            funct3_q  <= 3'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_fault <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            if (commit) begin
                rsp_rdata <= (c_we || fault) ? 32'd0 : rdata;
                rsp_fault <= fault;
            end
        end
    end
endmodule
